disp_scan_driver: RTL and testbench
===================================

# disp_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits. Accepts a packed hex value over a valid/ready load port and stages it so that value changes never tear mid-frame. Scans one digit per refresh period, feeding that digit's nibble through an internal `seven_segdisp` decoder. Sits between the ALU/result register and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; range 2..8.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `load_valid` input, 1 bit: `load_data` holds a new value.
- `load_ready` output, 1 bit: block can accept a load this cycle.
- `load_data` input, 4*NUM_DIGITS bits: packed nibbles; nibble k drives digit k, digit 0 is the LSB nibble.
- `seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-high, registered.
- `an` output, NUM_DIGITS bits: digit enables, one-cold (active-low), registered.
- `frame_done` output, 1 bit: one-cycle pulse when a full scan of all digits completes.

## Operation
- Registers:
  - `shown_q` holds the displayed value.
  - `staged_q` holds the accepted, not-yet-shown value.
  - `pending_q` flags that `staged_q` is valid.
  - `pre_q` is the prescaler, width $clog2(REFRESH_DIV).
  - `idx_q` is the digit index.
- Load handshake:
  - `load_ready = ~pending_q`, combinational from state only.
  - A load is accepted on a cycle with `load_valid & load_ready`. It writes `staged_q` and sets `pending_q`.
  - `load_data` is ignored when `load_ready` is 0.
- Prescaler:
  - `pre_q` counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the "tick".
- Digit index:
  - On a tick, `idx_q` advances 0→1→…→NUM_DIGITS-1→0.
  - The tick where `idx_q` goes from NUM_DIGITS-1 to 0 is the "frame end".
- At frame end:
  - `frame_done` pulses.
  - If `pending_q` was 1 before that edge, `shown_q` ← `staged_q` and `pending_q` clears.
  - A load accepted on the frame-end cycle itself is not committed at that frame end. It waits for the next frame end.
- Outputs:
  - `an` ← all ones, except bit `idx_q` = 0.
  - `seg` ← the decode of nibble `idx_q` of `shown_q`, or 0 when that digit is blanked.
- State machine: the two states are IDLE (`pending_q`=0) and STAGED (`pending_q`=1).
  - IDLE→STAGED on an accepted load.
  - STAGED→IDLE on frame end.
- Reset:
  - All registers clear: `shown_q`=0, `staged_q`=0, `pending_q`=0, `pre_q`=0, `idx_q`=0, `frame_done`=0.
  - `an` resets to all ones (all digits off); `seg` resets to 0.
  - `load_ready` is 1 while in reset.
  - Reset asserted mid-frame or with a load pending discards the staged value; nothing is committed.

## Timing
- `an` and `seg` lag `idx_q` by one cycle (one register stage).
- The first digit lights on the first clock edge after `rst_n` deasserts, showing digit 0 of value 0.
- Each digit is lit for exactly REFRESH_DIV cycles; one frame is NUM_DIGITS*REFRESH_DIV cycles.
- Load to display latency:
  - Minimum: 1 cycle, when a load is accepted exactly one cycle before frame end.
  - Maximum: one frame, NUM_DIGITS*REFRESH_DIV cycles.
- `frame_done` is registered. It is high in the cycle after the frame-end edge, aligned with the `an` change to digit 0.
- `load_ready` rises in the cycle after the frame end that commits a value.

## Configuration
- `DISP_LEADING_ZERO_BLANK_EN` defined:
  - Every digit k > 0 whose nibble and all higher nibbles of `shown_q` are zero has `seg` forced to 0.
  - `an` still scans that digit.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- `DISP_LEADING_ZERO_BLANK_EN` undefined: all digits always display, including leading zeros.

## Structure
- Package `disp_pkg` holds:
  - `seg_t` (logic [6:0]) and `SEG_BLANK` = 7'b0.
  - The STAGED/IDLE enum `disp_state_e`.
  - The `DISP_MAX_DIGITS` = 8 constant.
- Sub-module: one `seven_segdisp` instance, fed the selected nibble, with its output registered into `seg`.

## Test plan
- Reset release with NUM_DIGITS=4, REFRESH_DIV=4 → `an` steps through 1110, 1101, 1011, 0111, 4 cycles each; `seg` = 7'b0111111 on every digit (zero-blanking off); `frame_done` pulses every 16 cycles.
- Load 16'h1A3F mid-frame → `load_ready` drops the next cycle; digits keep showing 0 until frame end; then digit0=7'b1110001, digit1=7'b1001111, digit2=7'b1110111, digit3=7'b0000110; `load_ready` returns to 1.
- Hold `load_valid`=1 with a second value 16'h00FF while pending → the second value is not accepted; it is accepted the cycle `load_ready` rises and shows one frame later.
- Load accepted on the exact frame-end cycle → not committed at that frame end; committed at the following one.
- With `DISP_LEADING_ZERO_BLANK_EN`, load 16'h0005 → digits 3 and 2 have `seg`=0, digit 1 has `seg`=0, digit 0 has `seg`=7'b1101101. Load 16'h0000 → digit 0 shows 7'b0111111.
- Assert `rst_n`=0 mid-digit with a load pending → `an`=1111 and `seg`=0 immediately; after release, value 0 is displayed and `load_ready`=1.

Source files
------------

// File: rtl/disp_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Package name: disp_pkg. Optional feature macro used elsewhere:
// DISP_LEADING_ZERO_BLANK_EN (leading-zero blanking in the top level).
package disp_pkg;

    // Segment vector, bit order {g,f,e,d,c,b,a}, active-high.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;

    // Load-staging state: IDLE means nothing waiting, STAGED means
    // staged_q holds a value that will be shown at the next frame end.
    typedef enum logic {
        DISP_IDLE   = 1'b0,
        DISP_STAGED = 1'b1
    } disp_state_e;

    // Largest digit count the scan logic is sized for.
    localparam int DISP_MAX_DIGITS = 8;

endpackage

// File: rtl/disp_scan_driver_seven_segdisp.sv
// Hex nibble to common-anode 7-segment pattern decoder (segments active-high,
// order {g,f,e,d,c,b,a}). Purely combinational; the caller registers it.
module seven_segdisp
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Glyph table for 0-9 and A, b, C, d, E, F.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b011_1111;
            4'h1: seg = 7'b000_0110;
            4'h2: seg = 7'b101_1011;
            4'h3: seg = 7'b100_1111;
            4'h4: seg = 7'b110_0110;
            4'h5: seg = 7'b110_1101;
            4'h6: seg = 7'b111_1101;
            4'h7: seg = 7'b000_0111;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b110_1111;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b111_1100;
            4'hC: seg = 7'b011_1001;
            4'hD: seg = 7'b101_1110;
            4'hE: seg = 7'b111_1001;
            4'hF: seg = 7'b111_0001;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// A value is accepted over a valid/ready port into a staging register and
// only copied to the displayed register at a frame end, so a frame never
// mixes two values. One digit is lit per REFRESH_DIV clocks.
// Optional feature: define DISP_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is never blanked); undefined shows every digit.
module disp_scan_driver
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_IDLE   = 1'(DISP_IDLE);
    localparam logic [0:0] ST_STAGED = 1'(DISP_STAGED);

    logic [DATA_W-1:0]     shown_q;
    logic [DATA_W-1:0]     staged_q;
    logic [0:0]            state_q;
    logic                  pending_q;
    logic [PRE_W-1:0]      pre_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  fe_p0;

    logic                  tick;
    logic                  frame_end;
    logic                  accept;
    logic [3:0]            nib_sel;
    logic                  blank_sel;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            dec_seg;

    assign pending_q  = (state_q == ST_STAGED);
    assign load_ready = ~pending_q;
    assign accept     = load_valid & load_ready;
    assign tick       = (pre_q == PRE_LAST);
    assign frame_end  = tick & (idx_q == IDX_LAST);

    // Prescaler and digit index: one index step per REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    // Staging FSM: commit only a value that was already pending before the
    // frame-end edge; a load landing on that edge waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            staged_q <= '0;
            shown_q  <= '0;
        end else if (frame_end && pending_q) begin
            shown_q  <= staged_q;
            state_q  <= ST_IDLE;
        end else if (accept) begin
            staged_q <= load_data;
            state_q  <= ST_STAGED;
        end
    end

    // Leading-zero blank mask: digit k blanks when it and all higher nibbles are zero.
    always_comb begin
        blank = '0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        for (int k = 1; k < NUM_DIGITS; k++) begin
            blank[k] = ((shown_q >> (4 * k)) == '0);
        end
`endif
    end

    // Select the active digit's nibble, blank flag and one-cold anode pattern.
    always_comb begin
        nib_sel   = 4'h0;
        blank_sel = 1'b0;
        an_next   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel    = shown_q[4*k +: 4];
                blank_sel  = blank[k];
                an_next[k] = 1'b0;
            end
        end
    end

    seven_segdisp u_dec (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    // Output stage: pins lag idx_q by one cycle; frame_done aligns with digit 0 lighting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            fe_p0      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= blank_sel ? SEG_BLANK : dec_seg;
            fe_p0      <= frame_end;
            frame_done <= fe_p0;
        end
    end

endmodule

// File: tb/tb_disp_scan_driver.sv
// Directed bench for disp_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Honors DISP_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_disp_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    disp_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] hi;
        hi = v >> (4 * d);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if (d > 0 && hi == 16'h0000) return 7'b0000000;
`endif
        return hex_seg(hi[3:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Advance n cycles, checking the scan position, segment pattern of value v
    // and the frame pulse on every cycle. cyc counts edges since reset release.
    task automatic watch(input int n, input logic [15:0] v);
        int         d;
        logic [3:0] ea;
        logic       ef;
        for (int i = 0; i < n; i++) begin
            step();
            d  = ((cyc - 1) / RD) % ND;
            ea = ~(4'b0001 << d);
            ef = (cyc >= 17) && (((cyc - 1) % (ND * RD)) == 0);
            check($sformatf("an@%0d", cyc), an, ea);
            check($sformatf("seg@%0d", cyc), seg, exp_seg(v, d));
            check($sformatf("frame_done@%0d", cyc), frame_done, ef);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        repeat (3) @(negedge clk);
        check("an_rst", an, 4'hF);
        check("seg_rst", seg, 7'h00);
        check("ready_rst", load_ready, 1'b1);
        check("fd_rst", frame_done, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;

        // Free-running scan of value 0
        watch(20, 16'h0000);
        check("ready_idle", load_ready, 1'b1);

        // Mid-frame load of 1A3F
        load_valid = 1'b1;
        load_data  = 16'h1A3F;
        watch(1, 16'h0000);
        load_valid = 1'b0;
        check("ready_drop", load_ready, 1'b0);
        watch(10, 16'h0000);
        check("ready_hold", load_ready, 1'b0);
        watch(1, 16'h0000);
        check("ready_rise", load_ready, 1'b1);
        watch(16, 16'h1A3F);
        check("ready_after", load_ready, 1'b1);

        // 1234 pending while 00FF is held on the port
        load_valid = 1'b1;
        load_data  = 16'h1234;
        watch(1, 16'h1A3F);
        load_data  = 16'h00FF;
        check("ready_pend2", load_ready, 1'b0);
        watch(15, 16'h1A3F);
        check("ready_rise2", load_ready, 1'b1);
        watch(1, 16'h1234);
        load_valid = 1'b0;
        check("ready_held_acc", load_ready, 1'b0);
        watch(15, 16'h1234);
        watch(16, 16'h00FF);

        // Load on the frame-end cycle itself
        watch(15, 16'h00FF);
        load_valid = 1'b1;
        load_data  = 16'h4B6C;
        watch(1, 16'h00FF);
        load_valid = 1'b0;
        check("ready_fe_acc", load_ready, 1'b0);
        watch(15, 16'h00FF);
        check("ready_fe_wait", load_ready, 1'b0);
        watch(1, 16'h00FF);
        check("ready_fe_rise", load_ready, 1'b1);
        watch(16, 16'h4B6C);

        // Small values (leading zeros)
        load_valid = 1'b1;
        load_data  = 16'h0005;
        watch(1, 16'h4B6C);
        load_valid = 1'b0;
        watch(15, 16'h4B6C);
        watch(1, 16'h0005);
        check("seg_d0_five", seg, 7'b1101101);
        watch(15, 16'h0005);
        load_valid = 1'b1;
        load_data  = 16'h0000;
        watch(1, 16'h0005);
        load_valid = 1'b0;
        watch(15, 16'h0005);
        watch(1, 16'h0000);
        check("seg_d0_zero", seg, 7'b0111111);
        watch(15, 16'h0000);

        // Reset mid-digit with a load pending
        load_valid = 1'b1;
        load_data  = 16'h7777;
        watch(1, 16'h0000);
        load_valid = 1'b0;
        watch(1, 16'h0000);
        check("ready_pend_rst", load_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("an_async_rst", an, 4'hF);
        check("seg_async_rst", seg, 7'h00);
        check("ready_async_rst", load_ready, 1'b1);
        check("fd_async_rst", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        watch(20, 16'h0000);
        check("ready_post_rst", load_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
